// File: rtl/mcpu_ctrl_fsm_pkg.sv
// rtl/mcpu_ctrl_fsm_pkg.sv - shared encodings for the MCPU multi-cycle control sequencer
// Purpose: state encodings, opcode/funct constants, ALU command codes, mux-select
// encodings and the control-word layout shared by the sequencer and the datapath.
package mcpu_ctrl_fsm_pkg;

    localparam logic [4:0] RA_REG = 5'd31;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JR        = 4'd12,
        S_JAL       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_XOR  = 3'd2;
    localparam logic [2:0] ALU_SLT  = 3'd3;

    localparam logic [1:0] DST_RD   = 2'd0;
    localparam logic [1:0] DST_RT   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;

    localparam logic [1:0] SA_PC    = 2'd0;
    localparam logic [1:0] SA_A     = 2'd1;

    localparam logic [1:0] SB_IMMSH = 2'd0;
    localparam logic [1:0] SB_SEXT  = 2'd1;
    localparam logic [1:0] SB_B     = 2'd2;
    localparam logic [1:0] SB_FOUR  = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_JADDR  = 2'd1;
    localparam logic [1:0] PCS_ALUOUT = 2'd2;
    localparam logic [1:0] PCS_A      = 2'd3;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_we;
        logic       mem_in;
        logic       reg_we;
        logic       a_we;
        logic       b_we;
        logic [1:0] reg_dst;
        logic [1:0] reg_in;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Where DECODE goes for a given instruction; S_FETCH means unsupported.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW, OP_SW:     return S_MEM_ADDR;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: return S_R_EXEC;
                    FN_JR:                  return S_JR;
                    default:                return S_FETCH;
                endcase
            end
            OP_ADDI, OP_XORI: return S_I_EXEC;
            OP_BEQ, OP_BNE:   return S_BRANCH;
            OP_J:             return S_JUMP;
            OP_JAL:           return S_JAL;
            default:          return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// rtl/mcpu_ctrl_decode.sv - combinational state/opcode/funct to control-word decode
// Purpose: Moore decode of the control word from the current state.
// Ports:
//   i_state  current sequencer state
//   i_opcode opcode (live IR in DECODE, latched copy afterwards)
//   i_funct  IR funct field
//   i_zero   ALU zero flag, only consulted in BRANCH
//   o_ctrl   ungated control word
module mcpu_ctrl_decode
    import mcpu_ctrl_fsm_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.ir_we     = 1'b1;
                o_ctrl.alu_src_a = SA_PC;
                o_ctrl.alu_src_b = SB_FOUR;
                o_ctrl.alu_op    = ALU_ADD;
                o_ctrl.pc_src    = PCS_ALU;
                o_ctrl.pc_we     = 1'b1;
            end
            S_DECODE: begin
                // ALUOut <= PC + (sext imm << 2): all-zero selects already encode this.
                o_ctrl.a_we    = 1'b1;
                o_ctrl.b_we    = 1'b1;
                o_ctrl.illegal = (decode_target(i_opcode, i_funct) == S_FETCH);
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = SA_A;
                o_ctrl.alu_src_b = SB_SEXT;
                o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                o_ctrl.mem_in = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_dst    = DST_RT;
                o_ctrl.reg_in     = WD_MDR;
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_in     = 1'b1;
                o_ctrl.mem_we     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_R_EXEC: begin
                o_ctrl.alu_src_a = SA_A;
                o_ctrl.alu_src_b = SB_B;
                case (i_funct)
                    FN_SUB:  o_ctrl.alu_op = ALU_SUB;
                    FN_SLT:  o_ctrl.alu_op = ALU_SLT;
                    default: o_ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                o_ctrl.reg_dst    = DST_RD;
                o_ctrl.reg_in     = WD_ALUOUT;
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                o_ctrl.alu_src_a = SA_A;
                o_ctrl.alu_src_b = SB_SEXT;
                o_ctrl.alu_op    = (i_opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            S_I_WB: begin
                o_ctrl.reg_dst    = DST_RT;
                o_ctrl.reg_in     = WD_ALUOUT;
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                // Target was computed into ALUOut during DECODE.
                o_ctrl.alu_src_a  = SA_A;
                o_ctrl.alu_src_b  = SB_B;
                o_ctrl.alu_op     = ALU_SUB;
                o_ctrl.pc_src     = PCS_ALUOUT;
                o_ctrl.pc_we      = ((i_opcode == OP_BEQ) &&  i_zero) ||
                                    ((i_opcode == OP_BNE) && !i_zero);
                o_ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src     = PCS_JADDR;
                o_ctrl.pc_we      = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_JR: begin
                o_ctrl.pc_src     = PCS_A;
                o_ctrl.pc_we      = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value.
                o_ctrl.reg_dst    = DST_RA;
                o_ctrl.reg_in     = WD_PC;
                o_ctrl.reg_we     = 1'b1;
                o_ctrl.pc_src     = PCS_JADDR;
                o_ctrl.pc_we      = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// rtl/mcpu_ctrl_fsm.sv - multi-cycle MCPU control sequencer top
// Purpose: state register, latched opcode, next-state logic and stall/reset gating.
// Ports:
//   clk, reset (sync active-low), stall
//   opcode, funct (IR fields), zero (ALU flag)
//   pc_we, ir_we, mem_we, reg_we, a_we, b_we  write enables
//   mem_in, reg_dst, reg_in, alu_src_a, alu_src_b, alu_op, pc_src  selects
//   instr_done, illegal  single-cycle pulses
module mcpu_ctrl_fsm
    import mcpu_ctrl_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mem_we,
    output logic       mem_in,
    output logic       reg_we,
    output logic       a_we,
    output logic       b_we,
    output logic [1:0] reg_dst,
    output logic [1:0] reg_in,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    logic [5:0] w_dec_opcode;
    ctrl_t      w_dec;
    ctrl_t      w_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE && !stall)
                r_opcode <= opcode;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:   w_next = decode_target(opcode, funct);
            S_MEM_ADDR: w_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: w_next = S_MEM_WB;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            default:    w_next = S_FETCH;
        endcase
        if (stall)
            w_next = r_state;
    end

    // The latched copy is not valid until DECODE has passed, so DECODE sees the live IR.
    assign w_dec_opcode = (r_state == S_DECODE) ? opcode : r_opcode;

    mcpu_ctrl_decode u_decode (
        .i_state  (r_state),
        .i_opcode (w_dec_opcode),
        .i_funct  (funct),
        .i_zero   (zero),
        .o_ctrl   (w_dec)
    );

    // Reset clears everything; stall only kills enables and pulses, selects stay put.
    always_comb begin
        w_out = w_dec;
        if (!reset) begin
            w_out = '0;
        end else if (stall) begin
            w_out.pc_we      = 1'b0;
            w_out.ir_we      = 1'b0;
            w_out.mem_we     = 1'b0;
            w_out.reg_we     = 1'b0;
            w_out.a_we       = 1'b0;
            w_out.b_we       = 1'b0;
            w_out.instr_done = 1'b0;
            w_out.illegal    = 1'b0;
        end
    end

    assign pc_we      = w_out.pc_we;
    assign ir_we      = w_out.ir_we;
    assign mem_we     = w_out.mem_we;
    assign mem_in     = w_out.mem_in;
    assign reg_we     = w_out.reg_we;
    assign a_we       = w_out.a_we;
    assign b_we       = w_out.b_we;
    assign reg_dst    = w_out.reg_dst;
    assign reg_in     = w_out.reg_in;
    assign alu_src_a  = w_out.alu_src_a;
    assign alu_src_b  = w_out.alu_src_b;
    assign alu_op     = w_out.alu_op;
    assign pc_src     = w_out.pc_src;
    assign instr_done = w_out.instr_done;
    assign illegal    = w_out.illegal;

endmodule
